// File: rtl/lc3_alu_sequencer.sv
// Multi-cycle controller sequencing the LC-3 ALU datapath for ADD/AND/NOT.
// Handshakes one instruction, reads operands, runs the ALU, writes back and updates NZP.
module lc3_alu_sequencer #(
    parameter logic [2:0]  NZP_RESET = 3'b010,
    parameter int unsigned ALU_WAIT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_sr1,
    output logic [2:0]  rf_sr2,
    input  logic [15:0] rf_ra,
    input  logic [15:0] rf_rb,
    output logic [1:0]  alu_control,
    output logic [5:0]  alu_ir,
    output logic [15:0] alu_ra,
    output logic [15:0] alu_rb,
    input  logic [15:0] alu_out,
    output logic        rf_we,
    output logic [2:0]  rf_dr,
    output logic [15:0] rf_wdata,
    output logic [2:0]  nzp,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WRITE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ra_q, ra_d;
    logic [15:0] rb_q, rb_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  wait_q, wait_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [3:0]  opcode;
    logic        legal;

    assign opcode = ir_q[15:12];
    assign legal  = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);

    assign rf_sr1   = ir_q[8:6];
    assign rf_sr2   = ir_q[2:0];
    assign rf_dr    = ir_q[11:9];
    assign rf_wdata = result_q;
    assign alu_ra   = ra_q;
    assign alu_rb   = rb_q;
    assign nzp      = nzp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
            wait_q   <= '0;
            nzp_q    <= NZP_RESET;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
            wait_q   <= wait_d;
            nzp_q    <= nzp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        result_d    = result_q;
        wait_d      = wait_q;
        nzp_d       = nzp_q;
        instr_ready = 1'b0;
        alu_control = 2'b00;
        alu_ir      = '0;
        rf_we       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = READ;
                end else begin
                    illegal = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                ra_d    = rf_ra;
                rb_d    = rf_rb;
                wait_d  = WAIT_INIT;
                state_d = EXEC;
            end
            EXEC: begin
                // Only legal opcodes reach EXEC, so anything not ADD/AND is NOT.
                case (opcode)
                    4'b0001: alu_control = 2'b01;
                    4'b0101: alu_control = 2'b10;
                    default: alu_control = 2'b11;
                endcase
                alu_ir = ir_q[5:0];
                if (wait_q == 4'd0) begin
                    result_d = alu_out;
                    state_d  = WRITE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            WRITE: begin
                rf_we = 1'b1;
                done  = 1'b1;
                if (result_q[15])           nzp_d = 3'b100;
                else if (result_q == 16'h0) nzp_d = 3'b010;
                else                        nzp_d = 3'b001;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Directed bench for lc3_alu_sequencer: one instance with ALU_WAIT=0, one with ALU_WAIT=3,
// sharing a behavioural register file and ALU.
module tb_lc3_alu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] regs [8];
    logic        poke_en = 1'b0;
    logic [2:0]  poke_addr = '0;
    logic [15:0] poke_data = '0;

    logic        instr_valid0 = 1'b0, instr_valid1 = 1'b0;
    logic [15:0] instr0 = '0, instr1 = '0;
    logic        instr_ready0, instr_ready1;
    logic [2:0]  rf_sr1_0, rf_sr2_0, rf_sr1_1, rf_sr2_1;
    logic [15:0] rf_ra0, rf_rb0, rf_ra1, rf_rb1;
    logic [1:0]  alu_control0, alu_control1;
    logic [5:0]  alu_ir0, alu_ir1;
    logic [15:0] alu_ra0, alu_rb0, alu_ra1, alu_rb1;
    logic [15:0] alu_out0, alu_out1;
    logic        rf_we0, rf_we1;
    logic [2:0]  rf_dr0, rf_dr1;
    logic [15:0] rf_wdata0, rf_wdata1;
    logic [2:0]  nzp0, nzp1;
    logic        done0, done1, illegal0, illegal1;

    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] alu_f(input logic [1:0] c, input logic [15:0] a,
                                          input logic [15:0] b, input logic [5:0] ir);
        logic [15:0] op2;
        op2 = ir[5] ? {{11{ir[4]}}, ir[4:0]} : b;
        case (c)
            2'b00:   return a;
            2'b01:   return a + op2;
            2'b10:   return a & op2;
            default: return ~a;
        endcase
    endfunction

    assign rf_ra0   = regs[rf_sr1_0];
    assign rf_rb0   = regs[rf_sr2_0];
    assign rf_ra1   = regs[rf_sr1_1];
    assign rf_rb1   = regs[rf_sr2_1];
    assign alu_out0 = alu_f(alu_control0, alu_ra0, alu_rb0, alu_ir0);
    assign alu_out1 = alu_f(alu_control1, alu_ra1, alu_rb1, alu_ir1);

    always @(posedge clk) begin
        if (poke_en)     regs[poke_addr] <= poke_data;
        else if (rf_we0) regs[rf_dr0]    <= rf_wdata0;
        else if (rf_we1) regs[rf_dr1]    <= rf_wdata1;
    end

    lc3_alu_sequencer #(.NZP_RESET(3'b010), .ALU_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid0), .instr_ready(instr_ready0),
        .instr(instr0), .rf_sr1(rf_sr1_0), .rf_sr2(rf_sr2_0), .rf_ra(rf_ra0), .rf_rb(rf_rb0),
        .alu_control(alu_control0), .alu_ir(alu_ir0), .alu_ra(alu_ra0), .alu_rb(alu_rb0),
        .alu_out(alu_out0), .rf_we(rf_we0), .rf_dr(rf_dr0), .rf_wdata(rf_wdata0),
        .nzp(nzp0), .done(done0), .illegal(illegal0)
    );

    lc3_alu_sequencer #(.NZP_RESET(3'b010), .ALU_WAIT(3)) dut1 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid1), .instr_ready(instr_ready1),
        .instr(instr1), .rf_sr1(rf_sr1_1), .rf_sr2(rf_sr2_1), .rf_ra(rf_ra1), .rf_rb(rf_rb1),
        .alu_control(alu_control1), .alu_ir(alu_ir1), .alu_ra(alu_ra1), .alu_rb(alu_rb1),
        .alu_out(alu_out1), .rf_we(rf_we1), .rf_dr(rf_dr1), .rf_wdata(rf_wdata1),
        .nzp(nzp1), .done(done1), .illegal(illegal1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    // Present the word in cycle T; returns in cycle T+1.
    task automatic issue(input string tag, input logic [15:0] w);
        instr0 = w;
        instr_valid0 = 1'b1;
        check({tag, "_ready"}, 32'(instr_ready0), 32'd1);
        tick();
        instr_valid0 = 1'b0;
    endtask

    task automatic expect_write(input string tag, input int lat, input logic [2:0] dr,
                                input logic [15:0] data, input logic [2:0] exp_nzp);
        int n = 1;
        while (!rf_we0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_dr"}, 32'(rf_dr0), 32'(dr));
        check({tag, "_wdata"}, 32'(rf_wdata0), 32'(data));
        check({tag, "_done"}, 32'(done0), 32'd1);
        tick();
        check({tag, "_nzp"}, 32'(nzp0), 32'(exp_nzp));
        check({tag, "_ready_after"}, 32'(instr_ready0), 32'd1);
    endtask

    initial begin
        int n, w1, h2, w2, t;
        logic we_seen;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(instr_ready0), 32'd1);
        check("rst_nzp", 32'(nzp0), 32'h2);
        check("rst_we", 32'(rf_we0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_ctrl", 32'(alu_control0), 32'd0);
        check("rst_illegal", 32'(illegal0), 32'd0);
        check("rst_nzp1", 32'(nzp1), 32'h2);

        set_reg(3'd1, 16'd5);
        set_reg(3'd2, 16'd7);
        issue("add", 16'h1642);
        expect_write("add", 4, 3'd3, 16'h000C, 3'b001);

        set_reg(3'd1, 16'h7FFF);
        issue("wrap", 16'h1C61);
        expect_write("wrap", 4, 3'd6, 16'h8000, 3'b100);

        set_reg(3'd1, 16'h0000);
        issue("addimm", 16'h107F);
        expect_write("addimm", 4, 3'd0, 16'hFFFF, 3'b100);

        set_reg(3'd2, 16'h1234);
        issue("and", 16'h54A0);
        expect_write("and", 4, 3'd2, 16'h0000, 3'b010);

        set_reg(3'd5, 16'h00FF);
        issue("not", 16'h997F);
        expect_write("not", 4, 3'd4, 16'hFF00, 3'b100);

        issue("ill", 16'h0000);
        check("ill_illegal", 32'(illegal0), 32'd1);
        check("ill_done", 32'(done0), 32'd1);
        check("ill_we", 32'(rf_we0), 32'd0);
        tick();
        check("ill_ready", 32'(instr_ready0), 32'd1);
        check("ill_nzp", 32'(nzp0), 32'h4);
        check("ill_we2", 32'(rf_we0), 32'd0);

        // DR aliases both sources; operands must be the pre-write value.
        set_reg(3'd1, 16'd3);
        issue("alias", 16'h1241);
        expect_write("alias", 4, 3'd1, 16'd6, 3'b001);
        check("alias_reg", 32'(regs[1]), 32'd6);

        set_reg(3'd2, 16'd7);
        issue("rstx", 16'h1642);
        tick();
        tick();
        check("rstx_ctrl", 32'(alu_control0), 32'd1);
        check("rstx_ra", 32'(alu_ra0), 32'd6);
        check("rstx_rb", 32'(alu_rb0), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstx_we", 32'(rf_we0), 32'd0);
        check("rstx_nzp", 32'(nzp0), 32'h2);
        check("rstx_ready", 32'(instr_ready0), 32'd1);
        we_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            we_seen = we_seen | rf_we0;
        end
        check("rstx_no_we", 32'(we_seen), 32'd0);
        check("rstx_r3", 32'(regs[3]), 32'h000C);

        instr0 = 16'h1642;
        instr_valid0 = 1'b1;
        w1 = -1; h2 = -1; w2 = -1;
        for (t = 1; t <= 14; t++) begin
            tick();
            if (rf_we0) begin
                if (w1 < 0) w1 = t;
                else if (w2 < 0) w2 = t;
            end
            if (instr_ready0 && h2 < 0) h2 = t;
            else if (h2 >= 0) instr_valid0 = 1'b0;
        end
        instr_valid0 = 1'b0;
        check("b2b_w1", 32'(w1), 32'd4);
        check("b2b_h2", 32'(h2), 32'd5);
        check("b2b_w2", 32'(w2), 32'd9);
        check("b2b_data", 32'(regs[3]), 32'h000D);

        instr1 = 16'h1642;
        instr_valid1 = 1'b1;
        check("w3_ready", 32'(instr_ready1), 32'd1);
        tick();
        instr_valid1 = 1'b0;
        n = 1;
        while (!rf_we1 && n < 20) begin
            tick();
            n++;
        end
        check("w3_lat", 32'(n), 32'd7);
        check("w3_wdata", 32'(rf_wdata1), 32'h000D);
        check("w3_dr", 32'(rf_dr1), 32'd3);
        tick();
        check("w3_nzp", 32'(nzp1), 32'h1);
        check("w3_ready_after", 32'(instr_ready1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_alu_sequencer.md
Name: lc3_alu_sequencer

Overview:
- Multi-cycle controller that sequences the LC-3 ALU datapath for operate-class instructions: ADD (0001), AND (0101) and NOT (1001).
- Accepts one instruction over a valid/ready handshake and reads source registers from the register file.
- Drives the ALU control/immediate/operand inputs, writes the result back and maintains the NZP condition codes.
- Sits between the fetch/decode front end and the register file/ALU pair.

Parameters:
- NZP_RESET, 3'b010, condition-code value after reset (Z set).
- ALU_WAIT, 0, extra EXEC cycles (0..15) before the ALU result is captured; supports a retimed ALU path.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word available.
- instr_ready  out  1  sequencer idle and accepting.
- instr  in  16  LC-3 instruction; sampled only on handshake.
- rf_sr1  out  3  register-file read address A (IR[8:6]).
- rf_sr2  out  3  register-file read address B (IR[2:0]).
- rf_ra  in  16  register-file read data A; combinational from rf_sr1.
- rf_rb  in  16  register-file read data B; combinational from rf_sr2.
- alu_control  out  2  ALU function: 00 pass Ra, 01 add, 10 and, 11 not.
- alu_ir  out  6  ALU immediate field (IR[5:0]).
- alu_ra  out  16  ALU operand A (latched).
- alu_rb  out  16  ALU operand B (latched).
- alu_out  in  16  ALU result; combinational.
- rf_we  out  1  register write enable.
- rf_dr  out  3  destination register (IR[11:9]).
- rf_wdata  out  16  write data.
- nzp  out  3  condition codes {N,Z,P}.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when a non-operate opcode is rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; IR, operand latches, result register and wait counter clear to 0.
  - nzp goes to NZP_RESET.
  - rf_we, done and illegal go to 0; alu_control goes to 00.
  - Reset mid-operation aborts the instruction with no register write and no nzp update.
- FSM states: IDLE, DECODE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1 (instr_ready is 1 exactly when state==IDLE).
  - On instr_valid=1, latch instr into IR and go to DECODE.
  - instr_valid in any other state is ignored; the producer holds instr until the handshake.
- DECODE:
  - rf_sr1=IR[8:6] and rf_sr2=IR[2:0] (these are held through READ).
  - Opcode IR[15:12] in {0001, 0101, 1001}: go to READ.
  - Any other opcode: illegal=1 and done=1 this cycle, go to IDLE; no write, nzp unchanged.
- READ: latch rf_ra into alu_ra and rf_rb into alu_rb; go to EXEC.
- EXEC:
  - alu_control = 01 for ADD, 10 for AND, 11 for NOT; alu_ir = IR[5:0].
  - Wait counter loads ALU_WAIT on entry and decrements each cycle.
  - When the counter reads 0, capture alu_out into the result register and go to WRITE.
  - EXEC therefore lasts ALU_WAIT+1 cycles.
- WRITE:
  - rf_we=1, rf_dr=IR[11:9], rf_wdata=result, done=1.
  - nzp updates at the end of the cycle: 100 if result[15]=1; 010 if result==0; 001 otherwise. Exactly one bit is ever set.
  - Go to IDLE.
- Outside EXEC, alu_control=00 and alu_ir=0. Outside WRITE, rf_we=0.
- Latency: handshake accepted in cycle T gives DECODE at T+1, READ at T+2, EXEC at T+3.., and WRITE at T+4+ALU_WAIT. instr_ready returns to 1 at T+5+ALU_WAIT.
- Throughput: one instruction per 5+ALU_WAIT cycles.
- Immediate sign extension and arithmetic wrap-around are owned by the ALU. The sequencer forwards the 16-bit alu_out unmodified (0x7FFF+1 = 0x8000, nzp=100).
- Register aliasing (DR equal to SR1 or SR2) is safe: operands are latched in READ, before WRITE.

Test Plan:
- Reset check: hold rst for 2 cycles -> instr_ready=1, nzp=010, rf_we=0, done=0, alu_control=00.
- ADD R3,R1,R2 (0x1642) with R1=5, R2=7 -> in WRITE at T+4: rf_we=1, rf_dr=3, rf_wdata=0x000C, done=1; then nzp=001.
- ADD R0,R1,#-1 (0x107F) with R1=0 -> rf_wdata=0xFFFF, nzp=100.
- AND R2,R2,#0 (0x54A0) with R2=0x1234 -> rf_wdata=0x0000, nzp=010.
- NOT R4,R5 (0x997F) with R5=0x00FF -> rf_wdata=0xFF00, nzp=100.
- Opcode 0x0000 (BR) accepted -> illegal=1 and done=1 at T+1, rf_we never asserts, nzp unchanged, instr_ready=1 at T+2.
- Reset during EXEC, and ALU_WAIT=3:
  - Assert rst during EXEC of an ADD -> no rf_we pulse, nzp=NZP_RESET, IDLE next cycle.
  - With ALU_WAIT=3, the ADD write occurs at T+7 instead of T+4.
  - Back-to-back instr_valid held high -> second handshake at T+5, second write at T+9 (ALU_WAIT=0).
